data_memory_mmio: RTL
=====================

Name: data_memory_mmio

Overview:
- Byte-addressable data memory for the RISC-V core, with a parametrised word-RAM depth.
- Decodes load/store funct3 to do byte, half and word accesses, with sign or zero extension on loads.
- Provides a bank of memory-mapped output and input ports and a flash (preload) port that takes priority over the core.
- Sits between the core's load/store stage and the top-level I/O.

Parameters:
- DEPTH_WORDS, 2048: number of 32-bit RAM words; power of two, minimum 2.
- NUM_PORTS, 2: number of MMIO output registers and of input ports; range 1..8.
- MMIO_BASE, 32'h0000FFF0: byte address of port 0. Port i is at MMIO_BASE+4*i. Must be word aligned and above the RAM range.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- req  in  1  access request from the core this cycle
- wren  in  1  1 = store, 0 = load; qualified by req
- addr  in  32  byte address
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- wr_data  in  32  store data, right-aligned
- rd_data  out  32  load result, extended
- rd_valid  out  1  pulses one cycle after an accepted load
- flash_en  in  1  preload write; overrides the core
- flash_addr  in  32  byte address; [1:0] ignored
- flash_data  in  32  full word to write
- inport  in  32*NUM_PORTS  packed input ports, port i at bits [32*i+31:32*i]
- outport  out  32*NUM_PORTS  packed output registers
- misaligned  out  1  registered flag (see Optional Feature)

Behaviour:
- **Reset (rst=0, asynchronous):**
  - outport all 0, rd_data 0, rd_valid 0, misaligned 0.
  - RAM contents are not reset.
- **Address decode:**
  - MMIO hit when MMIO_BASE <= addr < MMIO_BASE+4*NUM_PORTS.
  - Otherwise RAM, with word index addr[$clog2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so the RAM aliases.
- **Flash:**
  - When flash_en=1, flash_data is written to word flash_addr[..:2] with all four byte lanes enabled.
  - Any core req in that cycle is dropped: no write, rd_valid=0 next cycle.
  - Flash never writes outport.
- **Store (req=1, wren=1, flash_en=0):**
  - SB: byte lane addr[1:0] gets wr_data[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} get wr_data[15:0].
  - SW: all lanes get wr_data.
  - Unselected lanes keep their value. Byte-lane enables are used; there is no read-modify-write.
  - MMIO store: outport[i] is loaded with the full wr_data at the clock edge, regardless of funct3. RAM is not written.
- **Load (req=1, wren=0, flash_en=0), latency 1:**
  - The accepted cycle registers funct3, addr[1:0] and the MMIO hit/index.
  - The next cycle gives rd_valid=1, and rd_data is the selected byte/half shifted to bit 0.
  - B/H sign-extend bit 7/15. BU/HU zero-extend. W passes through.
  - MMIO load returns the inport[i] value sampled at the accept edge, with the same extraction rules.
- **rd_data hold:** rd_data holds its last value while rd_valid=0.
- **Back-to-back:**
  - Loads may issue every cycle.
  - A store followed by a load to the same word returns the new data (write-before-read at the RAM, or bypass).
- **Illegal funct3 (011, 11x):** treated as W.
- **Reset mid-load:** rd_valid is forced to 0, and the pending load is discarded.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- **Defined:**
  - An H/HU access with addr[0]=1, or a W access with addr[1:0]!=0, is suppressed: no RAM write, no outport write.
  - misaligned=1 for exactly the cycle after the request. For a load, rd_valid=1 with rd_data=0 in that cycle.
- **Undefined:**
  - The offending low address bits are forced to zero: H uses addr[1], W uses lane 0. The access proceeds normally.
  - misaligned is tied to 0.

Test Plan:
1. Flash word 0x80FF7F01 at addr 0x0, then LB@0x0 -> 0x00000001; LB@0x1 -> 0x0000007F; LB@0x2 -> 0xFFFFFFFF; LBU@0x3 -> 0x00000080. rd_valid is 1 one cycle after each request.
2. Flash 0xAAAAAAAA at 0x8, then SB 0x11@0x9, then LW@0x8 -> 0xAAAA11AA. Then SH 0x2233@0xA, LW@0x8 -> 0x223311AA, and LH@0xA -> 0x00002233.
3. SW 0xDEADBEEF@MMIO_BASE+4 -> outport[1]=0xDEADBEEF at the next edge, outport[0] unchanged, RAM word at alias index unchanged. inport[0]=0x000000F0, LB@MMIO_BASE -> 0xFFFFFFF0.
4. flash_en=1 with simultaneous req SW 0x12345678@0x10 and flash 0xCAFEF00D@0x10 -> LW@0x10 returns 0xCAFEF00D; rd_valid stays 0 in the cycle after the dropped req.
5. Write outport[0]=0x5, issue LW, assert rst low mid-cycle -> outport=0 and rd_valid=0 immediately; after release, LW of an earlier-flashed word returns that word.
6. LW@0x2. With MEM_MISALIGN_TRAP_EN: misaligned=1 and rd_data=0 next cycle, and a following SH@0x1 leaves RAM unchanged. Without the macro: LW@0x2 returns word 0, and misaligned stays 0.

Source files
------------

// File: rtl/data_memory_mmio.sv
// Byte-addressable data RAM with memory-mapped output/input ports and a flash preload port.
// Optional build macro: MEM_MISALIGN_TRAP_EN (suppress and flag misaligned H/W accesses).
module data_memory_mmio #(
    parameter int          DEPTH_WORDS = 2048,
    parameter int          NUM_PORTS   = 2,
    parameter logic [31:0] MMIO_BASE   = 32'h0000FFF0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      wren,
    input  logic [31:0]               addr,
    input  logic [2:0]                funct3,
    input  logic [31:0]               wr_data,
    output logic [31:0]               rd_data,
    output logic                      rd_valid,
    input  logic                      flash_en,
    input  logic [31:0]               flash_addr,
    input  logic [31:0]               flash_data,
    input  logic [32*NUM_PORTS-1:0]   inport,
    output logic [32*NUM_PORTS-1:0]   outport,
    output logic                      misaligned
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MMIO_END = MMIO_BASE + 32'(4 * NUM_PORTS);

    // Shift the addressed lane to bit 0 and extend according to access size.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] off,
                                                 input logic is_b, input logic is_h, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        if (is_b) begin
            extract_load = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        end else if (is_h) begin
            extract_load = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end else begin
            extract_load = word;
        end
    endfunction

    logic [31:0]             mem_q [DEPTH_WORDS];
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    misaligned_q, misaligned_d;
    logic [32*NUM_PORTS-1:0] outport_q, outport_d;

    logic          core_s, mmio_hit_s, is_b_s, is_h_s, uns_s, trap_s, ram_we_s;
    logic [2:0]    mmio_idx_s;
    logic [1:0]    off_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_s, in_word_s, ld_word_s;
    logic [AW-1:0] ram_idx_s, flash_idx_s;
    logic          unused_flash_bits_s;

    assign unused_flash_bits_s = ^{flash_addr[31:AW+2], flash_addr[1:0]};

    // Address decode, lane steering and next-state for the registered outputs.
    always_comb begin
        core_s      = req & ~flash_en;
        mmio_hit_s  = (addr >= MMIO_BASE) && (addr < MMIO_END);
        mmio_idx_s  = 3'((addr - MMIO_BASE) >> 2);
        ram_idx_s   = addr[AW+1:2];
        flash_idx_s = flash_addr[AW+1:2];
        is_b_s      = (funct3[1:0] == 2'b00);
        is_h_s      = (funct3[1:0] == 2'b01);
        uns_s       = funct3[2] & ~funct3[1];
`ifdef MEM_MISALIGN_TRAP_EN
        trap_s      = (is_h_s & addr[0]) | (~is_b_s & ~is_h_s & (addr[1:0] != 2'b00));
`else
        trap_s      = 1'b0;
`endif
        // Misaligned H/W offsets collapse onto their natural alignment.
        if (is_b_s) begin
            off_s   = addr[1:0];
            be_s    = 4'b0001 << addr[1:0];
            wdata_s = {4{wr_data[7:0]}};
        end else if (is_h_s) begin
            off_s   = {addr[1], 1'b0};
            be_s    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{wr_data[15:0]}};
        end else begin
            off_s   = 2'b00;
            be_s    = 4'b1111;
            wdata_s = wr_data;
        end

        in_word_s = 32'h00000000;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (mmio_idx_s == 3'(i)) begin
                in_word_s = inport[32*i +: 32];
            end else begin
                in_word_s = in_word_s;
            end
        end
        ld_word_s = mmio_hit_s ? in_word_s : mem_q[ram_idx_s];

        ram_we_s     = core_s & wren & ~mmio_hit_s & ~trap_s;
        rd_valid_d   = core_s & ~wren;
        misaligned_d = core_s & trap_s;

        rd_data_d = rd_data_q;
        if (core_s & ~wren) begin
            rd_data_d = trap_s ? 32'h00000000 : extract_load(ld_word_s, off_s, is_b_s, is_h_s, uns_s);
        end else begin
            rd_data_d = rd_data_q;
        end

        outport_d = outport_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (core_s & wren & mmio_hit_s & ~trap_s & (mmio_idx_s == 3'(i))) begin
                outport_d[32*i +: 32] = wr_data;
            end else begin
                outport_d[32*i +: 32] = outport_q[32*i +: 32];
            end
        end
    end

    // Word RAM with per-byte write enables; flash preload wins over the core.
    always_ff @(posedge clk) begin
        if (flash_en) begin
            mem_q[flash_idx_s] <= flash_data;
        end else if (ram_we_s) begin
            for (int l = 0; l < 4; l++) begin
                if (be_s[l]) begin
                    mem_q[ram_idx_s][8*l +: 8] <= wdata_s[8*l +: 8];
                end
            end
        end
    end

    // Output registers; an asserted reset also discards any pending load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q    <= 32'h00000000;
            rd_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
            outport_q    <= '0;
        end else begin
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            misaligned_q <= misaligned_d;
            outport_q    <= outport_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign misaligned = misaligned_q;
    assign outport    = outport_q;

endmodule
